general_group_sequencer: RTL and testbench

//  Parametrised general-group control unit: decodes HALT/EI/DI/RETI/NOP

---
 rtl/general_group_sequencer_if.sv | 51 +++++
 rtl/general_group_sequencer.sv | 171 +++++++++++++++++
 tb/tb_general_group_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/general_group_sequencer_if.sv
// Bus between the instruction decoder / core and the general-group sequencer.
//
// master : decoder/core side; drives phase strobes, opcode, interrupt lines
//          and acknowledge, and observes the sequencer outputs.
// slave  : the sequencer itself.
//
// Signals
//   execute, commit    phase strobes (commit marks the instruction boundary)
//   instruction_op     general-group opcode, valid with the strobes
//   irq, irq_mask      level interrupt requests and per-line enables
//   int_ack            core accepts int_req (1-cycle pulse)
//   eix, dix, retix    1-cycle strobes, cycle after execute
//   haltx              1-cycle strobe, cycle after commit of HALT
//   ie                 interrupt-enable flag
//   int_req            interrupt request to the core
//   int_vector         winning interrupt line
//   halted             sequencer is in the HALTED state
//   wake               1-cycle strobe on HALTED->RUN
//   stack_err          sticky: RETI executed with an empty IE stack
interface general_group_sequencer_if #(
    parameter int OP_W    = 4,
    parameter int NUM_IRQ = 4,
    parameter int VEC_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
);
    logic               execute;
    logic               commit;
    logic [OP_W-1:0]    instruction_op;
    logic [NUM_IRQ-1:0] irq;
    logic [NUM_IRQ-1:0] irq_mask;
    logic               int_ack;
    logic               eix;
    logic               dix;
    logic               retix;
    logic               haltx;
    logic               ie;
    logic               int_req;
    logic [VEC_W-1:0]   int_vector;
    logic               halted;
    logic               wake;
    logic               stack_err;

    modport master (
        output execute, commit, instruction_op, irq, irq_mask, int_ack,
        input  eix, dix, retix, haltx, ie, int_req, int_vector, halted, wake, stack_err
    );

    modport slave (
        input  execute, commit, instruction_op, irq, irq_mask, int_ack,
        output eix, dix, retix, haltx, ie, int_req, int_vector, halted, wake, stack_err
    );
endinterface

// File: rtl/general_group_sequencer.sv
// General-group control unit. Decodes HALT/EI/DI/RETI, issues phase-aligned
// strobes, owns the interrupt-enable flag (with a one-instruction EI shadow),
// prioritised pending interrupts, a nested IE save stack and a RUN/HALTED
// state machine that wakes on any enabled interrupt line.
//
// Ports
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   general_group_sequencer_if.slave (see interface header)
module general_group_sequencer #(
    parameter int OP_W       = 4,
    parameter int OP_HALT    = 0,
    parameter int OP_EI      = 1,
    parameter int OP_DI      = 2,
    parameter int OP_RETI    = 3,
    parameter int NUM_IRQ    = 4,
    parameter int NEST_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    general_group_sequencer_if.slave  bus
);
    localparam int VEC_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int DEPTH_W = $clog2(NEST_DEPTH + 1);
    // Power-of-two storage so any depth-counter value is a legal index.
    localparam int STK_N   = 1 << DEPTH_W;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [0:0]         state;
    logic               ie;
    logic               shadow;
    logic               int_req;
    logic [VEC_W-1:0]   int_vector;
    logic               stack_err;
    logic               eix_p1, dix_p1, retix_p1, haltx_p1, wake_p1;
    logic [NUM_IRQ-1:0] pend;
    logic [DEPTH_W-1:0] depth;
    logic               stack [STK_N];

    logic               dec_ei, dec_di, dec_reti, dec_halt;
    logic [NUM_IRQ-1:0] irq_live, eligible, ack_clr;
    logic [VEC_W-1:0]   win_vec;
    logic               win_any;
    logic               stack_empty, stack_full;
    logic [DEPTH_W-1:0] top_idx, push_idx, depth_nxt;
    logic               pop_val, push_val;
    logic               ack_ok, req_cond;

    // Opcode decode; unknown opcodes leave every flag low.
    always_comb begin
        dec_ei   = 1'b0;
        dec_di   = 1'b0;
        dec_reti = 1'b0;
        dec_halt = 1'b0;
        if (bus.execute) begin
            if (bus.instruction_op == OP_W'(OP_EI))        dec_ei   = 1'b1;
            else if (bus.instruction_op == OP_W'(OP_DI))   dec_di   = 1'b1;
            else if (bus.instruction_op == OP_W'(OP_RETI)) dec_reti = 1'b1;
        end
        if (bus.commit && (bus.instruction_op == OP_W'(OP_HALT))) dec_halt = 1'b1;
    end

    assign irq_live = bus.irq & bus.irq_mask;
    assign eligible = pend & bus.irq_mask;

    // Lowest-index eligible line wins: scan downwards so the last hit is lowest.
    always_comb begin
        win_vec = '0;
        win_any = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_vec = VEC_W'(i);
                win_any = 1'b1;
            end
        end
    end

    assign stack_empty = (depth == '0);
    assign stack_full  = (depth == DEPTH_W'(NEST_DEPTH));
    assign top_idx     = depth - DEPTH_W'(1);
    // Popping an empty stack yields IE=1 (and flags the error).
    assign pop_val     = stack_empty ? 1'b1 : stack[top_idx];
    assign ack_ok      = bus.int_ack & int_req;
    assign req_cond    = ie & ~shadow & win_any & ~stack_full;
    assign ack_clr     = ack_ok ? (NUM_IRQ'(1) << int_vector) : '0;

    // Stack pointer update. ACK together with RETI is a pop followed by a push
    // of the popped value, so a non-empty stack keeps its depth and top entry.
    always_comb begin
        push_idx  = depth;
        push_val  = ie;
        depth_nxt = depth;
        if (ack_ok && dec_reti) begin
            push_idx  = stack_empty ? '0 : top_idx;
            push_val  = pop_val;
            depth_nxt = stack_empty ? DEPTH_W'(1) : depth;
        end else if (ack_ok) begin
            depth_nxt = depth + DEPTH_W'(1);
        end else if (dec_reti && !stack_empty) begin
            depth_nxt = top_idx;
        end
    end

    // Stack contents carry no reset; depth alone defines validity.
    always_ff @(posedge clk) begin
        if (ack_ok) stack[push_idx] <= push_val;
    end

    // Control state, strobes and interrupt request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            ie         <= 1'b0;
            shadow     <= 1'b0;
            int_req    <= 1'b0;
            int_vector <= '0;
            stack_err  <= 1'b0;
            pend       <= '0;
            depth      <= '0;
            eix_p1     <= 1'b0;
            dix_p1     <= 1'b0;
            retix_p1   <= 1'b0;
            haltx_p1   <= 1'b0;
            wake_p1    <= 1'b0;
        end else begin
            eix_p1   <= dec_ei;
            dix_p1   <= dec_di;
            retix_p1 <= dec_reti;
            haltx_p1 <= dec_halt;

            // An accepted interrupt always leaves IE clear, whatever else executes.
            if (ack_ok)        ie <= 1'b0;
            else if (dec_reti) ie <= pop_val;
            else if (dec_ei)   ie <= 1'b1;
            else if (dec_di)   ie <= 1'b0;

            if (dec_ei && !ack_ok) shadow <= 1'b1;
            else if (bus.commit)   shadow <= 1'b0;

            if (dec_reti && stack_empty) stack_err <= 1'b1;

            depth <= depth_nxt;
            pend  <= (pend | irq_live) & ~ack_clr;

            int_req <= ack_ok ? 1'b0 : req_cond;
            // Freeze the vector while a request is outstanding.
            if (!int_req || ack_ok) int_vector <= win_vec;

            wake_p1 <= 1'b0;
            if (state == ST_RUN) begin
                if (dec_halt) state <= ST_HALTED;
            end else if (|irq_live) begin
                state   <= ST_RUN;
                wake_p1 <= 1'b1;
            end
        end
    end

    assign bus.eix        = eix_p1;
    assign bus.dix        = dix_p1;
    assign bus.retix      = retix_p1;
    assign bus.haltx      = haltx_p1;
    assign bus.ie         = ie;
    assign bus.int_req    = int_req;
    assign bus.int_vector = int_vector;
    assign bus.halted     = (state == ST_HALTED);
    assign bus.wake       = wake_p1;
    assign bus.stack_err  = stack_err;
endmodule

// File: tb/tb_general_group_sequencer.sv
// Directed bench for general_group_sequencer: reset abort, EI shadow,
// arbitration, nesting limit, stack underflow, halt/wake and simultaneous
// ACK/DI and EXECUTE/COMMIT cases. Expected interrupt vectors are queued
// when the interrupt stimulus is applied and popped when INT_REQ rises.
module tb_general_group_sequencer;
    localparam int OP_W    = 4;
    localparam int NUM_IRQ = 4;
    localparam int VEC_W   = 2;
    localparam logic [3:0] OP_HALT = 4'd0;
    localparam logic [3:0] OP_EI   = 4'd1;
    localparam logic [3:0] OP_DI   = 4'd2;
    localparam logic [3:0] OP_RETI = 4'd3;
    localparam logic [3:0] OP_UNK  = 4'hC;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [VEC_W-1:0] exp_q [$];

    general_group_sequencer_if #(.OP_W(OP_W), .NUM_IRQ(NUM_IRQ), .VEC_W(VEC_W)) bus ();

    general_group_sequencer #(
        .OP_W(OP_W), .OP_HALT(0), .OP_EI(1), .OP_DI(2), .OP_RETI(3),
        .NUM_IRQ(NUM_IRQ), .NEST_DEPTH(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exec_op(input logic [3:0] op);
        bus.instruction_op = op;
        bus.execute        = 1'b1;
        cyc();
        bus.execute        = 1'b0;
    endtask

    task automatic commit_op(input logic [3:0] op);
        bus.instruction_op = op;
        bus.commit         = 1'b1;
        cyc();
        bus.commit         = 1'b0;
    endtask

    task automatic ack();
        bus.int_ack = 1'b1;
        cyc();
        bus.int_ack = 1'b0;
    endtask

    // Wait (bounded) for INT_REQ, then compare the vector with the queued one.
    task automatic wait_req(input string tag);
        bit got;
        logic [VEC_W-1:0] exp_v;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.int_req === 1'b1) begin
                got = 1'b1;
                break;
            end
            cyc();
        end
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL %s_timeout: int_req observed 0 expected 1", tag);
        end
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            if (got) chk({tag, "_vec"}, 32'(bus.int_vector), 32'(exp_v));
        end
    endtask

    initial begin
        checks             = 0;
        errors             = 0;
        rst                = 1'b1;
        bus.execute        = 1'b0;
        bus.commit         = 1'b0;
        bus.instruction_op = OP_UNK;
        bus.irq            = '0;
        bus.irq_mask       = 4'hF;
        bus.int_ack        = 1'b0;
        cyc();
        cyc();
        chk("rst_outputs", {28'd0, bus.ie, bus.int_req, bus.halted, bus.stack_err}, 32'd0);
        chk("rst_strobes", {27'd0, bus.eix, bus.dix, bus.retix, bus.haltx, bus.wake}, 32'd0);
        rst = 1'b0;

        // 1: reset asserted in the middle of an EI
        exec_op(OP_EI);
        chk("t1_ei_ie", 32'(bus.ie), 32'd1);
        chk("t1_ei_eix", 32'(bus.eix), 32'd1);
        bus.instruction_op = OP_EI;
        bus.execute        = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("t1_async_rst", {30'd0, bus.ie, bus.eix}, 32'd0);
        bus.execute = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        chk("t1_ie_after_rst", 32'(bus.ie), 32'd0);

        // Unknown opcode produces no strobe
        exec_op(OP_UNK);
        chk("unk_no_strobe", {28'd0, bus.eix, bus.dix, bus.retix, bus.haltx}, 32'd0);

        // 2: EI shadow holds off the request until the next commit
        exec_op(OP_EI);
        bus.irq = 4'b0100;
        exp_q.push_back(2'd2);
        cyc();
        bus.irq = '0;
        cyc();
        cyc();
        chk("t2_shadow_no_req", 32'(bus.int_req), 32'd0);
        commit_op(OP_EI);
        wait_req("t2_req");
        ack();
        chk("t2_ack_ie", {30'd0, bus.ie, bus.int_req}, 32'd0);
        exec_op(OP_RETI);
        chk("t2_reti_ie", 32'(bus.ie), 32'd1);

        // 3: arbitration picks line 1, then line 3 after RETI
        bus.irq = 4'b1010;
        exp_q.push_back(2'd1);
        cyc();
        bus.irq = '0;
        wait_req("t3_first");
        ack();
        chk("t3_ack_ie", 32'(bus.ie), 32'd0);
        cyc();
        cyc();
        chk("t3_no_req_ie0", 32'(bus.int_req), 32'd0);
        exec_op(OP_RETI);
        chk("t3_retix", 32'(bus.retix), 32'd1);
        chk("t3_reti_ie", 32'(bus.ie), 32'd1);
        exp_q.push_back(2'd3);
        wait_req("t3_second");
        ack();
        exec_op(OP_RETI);
        chk("t3_restore_ie", 32'(bus.ie), 32'd1);

        // 4: four nested acknowledges fill the stack, then five RETIs
        bus.irq = 4'b0001;
        for (int n = 0; n < 4; n++) begin
            exp_q.push_back(2'd0);
            wait_req("t4_nest");
            ack();
            chk("t4_nest_ie", 32'(bus.ie), 32'd0);
            exec_op(OP_EI);
            commit_op(OP_EI);
        end
        cyc();
        cyc();
        cyc();
        chk("t4_full_no_req", 32'(bus.int_req), 32'd0);
        bus.irq = '0;
        for (int n = 0; n < 4; n++) begin
            exec_op(OP_RETI);
            chk("t4_pop_ie_err", {30'd0, bus.ie, bus.stack_err}, 32'd2);
        end
        exec_op(OP_RETI);
        chk("t4_underflow", {30'd0, bus.ie, bus.stack_err}, 32'd3);

        // 5: halt with IE=0, wake on IRQ[0]
        exec_op(OP_DI);
        chk("t5_di", {30'd0, bus.ie, bus.dix}, 32'd1);
        cyc();
        commit_op(OP_HALT);
        chk("t5_haltx", {30'd0, bus.haltx, bus.halted}, 32'd3);
        cyc();
        chk("t5_halted_hold", {29'd0, bus.haltx, bus.halted, bus.wake}, 32'd2);
        bus.irq = 4'b0001;
        cyc();
        chk("t5_wake", {30'd0, bus.wake, bus.halted}, 32'd2);
        bus.irq = '0;
        cyc();
        chk("t5_after_wake", {30'd0, bus.wake, bus.int_req}, 32'd0);

        // 6: ACK and DI together, then EXECUTE+COMMIT of HALT together
        exec_op(OP_EI);
        commit_op(OP_EI);
        exp_q.push_back(2'd0);
        wait_req("t6_req");
        bus.int_ack        = 1'b1;
        bus.instruction_op = OP_DI;
        bus.execute        = 1'b1;
        cyc();
        bus.int_ack = 1'b0;
        bus.execute = 1'b0;
        chk("t6_ack_di", {29'd0, bus.ie, bus.dix, bus.int_req}, 32'd2);
        exec_op(OP_RETI);
        chk("t6_stack_top", 32'(bus.ie), 32'd1);
        chk("t6_err_sticky", 32'(bus.stack_err), 32'd1);
        bus.instruction_op = OP_HALT;
        bus.execute        = 1'b1;
        bus.commit         = 1'b1;
        cyc();
        bus.execute = 1'b0;
        bus.commit  = 1'b0;
        chk("t6_exec_commit_halt", {27'd0, bus.haltx, bus.halted, bus.eix, bus.dix, bus.retix}, 32'h18);
        cyc();
        chk("t6_haltx_pulse", 32'(bus.haltx), 32'd0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
